// File: rtl/display_pkg.sv
// display_pkg: segment patterns, 7-segment typedef and active-low polarity constants
package display_pkg;
    typedef logic [6:0] seg7_t;
    localparam logic  AN_ON   = 1'b0;
    localparam logic  AN_OFF  = 1'b1;
    localparam logic  DP_ON   = 1'b0;
    localparam logic  DP_OFF  = 1'b1;
    localparam seg7_t SEG_OFF = 7'h7F;
    localparam seg7_t SEG_0   = 7'b1000000;
    localparam seg7_t SEG_1   = 7'b1111001;
    localparam seg7_t SEG_2   = 7'b0100100;
    localparam seg7_t SEG_3   = 7'b0110000;
    localparam seg7_t SEG_4   = 7'b0011001;
    localparam seg7_t SEG_5   = 7'b0010010;
    localparam seg7_t SEG_6   = 7'b0000010;
    localparam seg7_t SEG_7   = 7'b1111000;
    localparam seg7_t SEG_8   = 7'b0000000;
    localparam seg7_t SEG_9   = 7'b0010000;
    localparam seg7_t SEG_A   = 7'b0001000;
    localparam seg7_t SEG_B   = 7'b0000011;
    localparam seg7_t SEG_C   = 7'b1000110;
    localparam seg7_t SEG_D   = 7'b0100001;
    localparam seg7_t SEG_E   = 7'b0000110;
    localparam seg7_t SEG_F   = 7'b0001110;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low {g..a} segment pattern, letters optional
module seg7_decode
    import display_pkg::*;
#(
    parameter bit HEX_EN = 1'b1
) (
    input  logic [3:0] nib,
    output seg7_t      seg
);
    // table lookup; codes above 9 become letters or stay dark
    always_comb begin
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = HEX_EN ? SEG_A : SEG_OFF;
            4'd11:   seg = HEX_EN ? SEG_B : SEG_OFF;
            4'd12:   seg = HEX_EN ? SEG_C : SEG_OFF;
            4'd13:   seg = HEX_EN ? SEG_D : SEG_OFF;
            4'd14:   seg = HEX_EN ? SEG_E : SEG_OFF;
            default: seg = HEX_EN ? SEG_F : SEG_OFF;
        endcase
    end
endmodule

// File: rtl/display_7seg_scan.sv
// display_7seg_scan: time-multiplexed common-anode 7-segment driver with frame-synchronous snapshot
module display_7seg_scan
    import display_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit HEX_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzb_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] val_q, val_d;
    logic [N_DIGITS-1:0]   dps_q, dps_d;
    seg7_t                 seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  slot_end, frame_end, blank;
    logic [3:0]            nib;
    seg7_t                 dec;
    logic [N_DIGITS:0]     lead;

    assign slot_end  = cnt_q == CNT_LAST;
    assign frame_end = slot_end && idx_q == IDX_LAST;
    assign nib       = val_q[{idx_q, 2'b00} +: 4];

    seg7_decode #(.HEX_EN(HEX_EN)) u_dec (
        .nib (nib),
        .seg (dec)
    );

    // lead[i] is set when shadow digits i..N_DIGITS-1 are all zero
    always_comb begin
        lead[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) lead[i] = lead[i+1] && val_q[4*i +: 4] == 4'd0;
    end

    assign blank = lzb_en && idx_q != '0 && lead[idx_q];

    // scan counters, frame snapshot and next pin pattern (dark on the last cycle of each slot)
    always_comb begin
        cnt_d  = slot_end ? '0 : cnt_q + 1'b1;
        idx_d  = slot_end ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
        val_d  = frame_end ? value : val_q;
        dps_d  = frame_end ? dp_in : dps_q;
        tick_d = frame_end;
        an_d   = slot_end ? {N_DIGITS{AN_OFF}} : ~(N_DIGITS'(1) << idx_q);
        seg_d  = (slot_end || blank) ? SEG_OFF : dec;
        dp_d   = slot_end ? DP_OFF : (dps_q[idx_q] ? DP_ON : DP_OFF);
    end

    // state and registered outputs, all cleared to the dark pattern on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            val_q  <= '0;
            dps_q  <= '0;
            tick_q <= 1'b0;
            an_q   <= {N_DIGITS{AN_OFF}};
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            dps_q  <= dps_d;
            tick_q <= tick_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_display_7seg_scan.sv
// tb_display_7seg_scan: directed checks of scan order, decode, LZB, snapshot timing, dp and reset
module tb_display_7seg_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lzb_en;
    logic [6:0]  seg, seg_nh;
    logic        dp, dp_nh;
    logic [3:0]  an, an_nh;
    logic        ft, ft_nh;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    display_7seg_scan #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lzb_en(lzb_en),
        .seg(seg), .dp(dp), .an(an), .frame_tick(ft)
    );

    display_7seg_scan #(.N_DIGITS(4), .REFRESH_DIV(4), .HEX_EN(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .lzb_en(lzb_en),
        .seg(seg_nh), .dp(dp_nh), .an(an_nh), .frame_tick(ft_nh)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic off(input string tag);
        chk({tag, ".an"}, 32'(an), 32'h0000_000F);
        chk({tag, ".seg"}, 32'(seg), 32'h0000_007F);
        chk({tag, ".dp"}, 32'(dp), 32'h1);
        chk({tag, ".an_nh"}, 32'(an_nh), 32'h0000_000F);
        chk({tag, ".seg_nh"}, 32'(seg_nh), 32'h0000_007F);
    endtask

    task automatic digit(input string tag, input logic [3:0] a, input logic [6:0] s,
                         input logic [6:0] snh, input logic d);
        for (int k = 0; k < 3; k++) begin
            step();
            chk({tag, ".an"}, 32'(an), 32'(a));
            chk({tag, ".seg"}, 32'(seg), 32'(s));
            chk({tag, ".seg_nh"}, 32'(seg_nh), 32'(snh));
            chk({tag, ".an_nh"}, 32'(an_nh), 32'(a));
            chk({tag, ".dp"}, 32'(dp), 32'(d));
            chk({tag, ".tick"}, 32'(ft), 32'h0);
        end
        step();
        off({tag, ".dark"});
        chk({tag, ".tick_end"}, 32'(ft), 32'(a == 4'h7));
        chk({tag, ".tick_nh"}, 32'(ft_nh), 32'(a == 4'h7));
    endtask

    task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic [6:0] n0,
                         input logic [6:0] n1, input logic [6:0] n2, input logic [6:0] n3);
        digit({tag, ".d0"}, 4'hE, s0, n0, 1'b1);
        digit({tag, ".d1"}, 4'hD, s1, n1, 1'b1);
        digit({tag, ".d2"}, 4'hB, s2, n2, 1'b1);
        digit({tag, ".d3"}, 4'h7, s3, n3, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        value = 16'h1234;
        dp_in = 4'b0000;
        lzb_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            off("rst");
            chk("rst.tick", 32'(ft), 32'h0);
        end
        rst = 1'b0;
        off("rel");
        chk("rel.tick", 32'(ft), 32'h0);
        frame("f1_zero", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        frame("f2_1234", 7'h19, 7'h30, 7'h24, 7'h79, 7'h19, 7'h30, 7'h24, 7'h79);
        value = 16'hFACE;
        frame("f3_1234", 7'h19, 7'h30, 7'h24, 7'h79, 7'h19, 7'h30, 7'h24, 7'h79);
        value = 16'h0050;
        lzb_en = 1'b1;
        frame("f4_face", 7'h06, 7'h46, 7'h08, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        value = 16'h0000;
        frame("f5_lzb50", 7'h40, 7'h12, 7'h7F, 7'h7F, 7'h40, 7'h12, 7'h7F, 7'h7F);
        value = 16'h1111;
        frame("f6_lzb00", 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F);
        lzb_en = 1'b0;
        digit("f7.d0", 4'hE, 7'h79, 7'h79, 1'b1);
        value = 16'h2222;
        digit("f7.d1", 4'hD, 7'h79, 7'h79, 1'b1);
        digit("f7.d2", 4'hB, 7'h79, 7'h79, 1'b1);
        digit("f7.d3", 4'h7, 7'h79, 7'h79, 1'b1);
        dp_in = 4'b0100;
        frame("f8_2222", 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24, 7'h24);
        digit("f9.d0", 4'hE, 7'h24, 7'h24, 1'b1);
        digit("f9.d1", 4'hD, 7'h24, 7'h24, 1'b1);
        step();
        chk("f9.d2.an", 32'(an), 32'hB);
        chk("f9.d2.seg", 32'(seg), 32'h24);
        chk("f9.d2.dp", 32'(dp), 32'h0);
        chk("f9.d2.dp_nh", 32'(dp_nh), 32'h0);
        rst = 1'b1;
        step();
        off("midrst");
        chk("midrst.tick", 32'(ft), 32'h0);
        rst = 1'b0;
        digit("post.d0", 4'hE, 7'h40, 7'h40, 1'b1);
        digit("post.d1", 4'hD, 7'h40, 7'h40, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_7seg_scan.md
# display_7seg_scan

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It sits between the datapath, which presents one 4-bit code per digit, and the board pins, which carry shared active-low segment lines and per-digit active-low anode enables. It adds hexadecimal decoding, per-digit decimal points, optional leading-zero blanking, frame-synchronous latching of the displayed value (no tearing), and a one-cycle anti-ghosting blank between digit slots.

## Interface
- `N_DIGITS`, default 4: number of digits scanned, at least 1.
- `REFRESH_DIV`, default 50000: clock cycles per digit slot, at least 2.
- `HEX_EN`, default 1: 1 decodes codes 10–15 as A b C d E F; 0 blanks codes above 9.

Ports, clock and reset first:
- `clk`  in  1: single clock. All state is updated on the rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `value`  in  4*N_DIGITS: digit codes. Digit i is `value[4i+3:4i]`; digit 0 is least significant and rightmost.
- `dp_in`  in  N_DIGITS: decimal-point request per digit, 1 = lit.
- `lzb_en`  in  1: leading-zero blanking enable.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, bit 6 = g, active-low.
- `dp`  out  1: decimal point, active-low.
- `an`  out  N_DIGITS: anode enables, active-low, one-hot-low while a digit is lit.
- `frame_tick`  out  1: one-cycle pulse when a new `value`/`dp_in` snapshot is latched.

## Operation
- **Slot counter `cnt`:** counts 0 to REFRESH_DIV-1, then wraps to 0.
- **Digit index `idx`:** counts 0 to N_DIGITS-1.
  - Advances only when `cnt` = REFRESH_DIV-1.
  - Wraps from N_DIGITS-1 to 0.
  - Scan order is 0, 1, …, N_DIGITS-1, 0, …
- **Frame end** is the cycle where `cnt` = REFRESH_DIV-1 and `idx` = N_DIGITS-1. In that cycle:
  - The shadow registers load `value` and `dp_in`.
  - `frame_tick` is registered high for exactly the next cycle.
- **Display source:** the display reads only the shadow registers. Input changes therefore appear at the next frame boundary, never mid-frame.
- **Output registers (`seg`, `dp`, `an`):** updated every cycle.
  - If `cnt` = REFRESH_DIV-1, they load the off pattern: `an` all 1, `seg` = 7'h7F, `dp` = 1. This is the anti-ghost blank.
  - Otherwise they load the decode of shadow digit `idx`:
    - `an[idx]` = 0, all other anode bits 1.
    - `seg` is set by the decode table below, with LZB applied.
    - `dp` = ~`dp_shadow[idx]`.
- **Decode table (active-low {g..a}):**
  - Digits 0–9: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Letters, when HEX_EN=1: A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
  - When HEX_EN=0, codes 10–15 give 1111111.
- **LZB:** when `lzb_en`=1, digit i>0 shows `seg` = 7'h7F if shadow nibbles i..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - `an` is still driven low for a blanked digit.
  - `dp` is still honoured for a blanked digit.
- `lzb_en` is sampled live (not shadowed).

## Timing
- **Reset values** (while `rst` is high and in the first cycle after it releases):
  - Outputs: `seg` = 7'h7F, `dp` = 1, `an` = all 1, `frame_tick` = 0.
  - Internal state: `cnt` = 0, `idx` = 0, shadow value = 0, shadow dp = 0.
- **First frame after reset** shows the zero shadow. The first snapshot of `value` is taken at the end of that frame.
- **Latency:** one cycle from (`cnt`, `idx`) to the pins.
- **Per slot:** the digit is lit for REFRESH_DIV-1 cycles and dark for 1 cycle.
- **Frame period:** N_DIGITS × REFRESH_DIV cycles. `frame_tick` has the same period.
- **Reset mid-slot or mid-frame:** outputs go off on the next edge and the scan restarts at digit 0. No partial snapshot is taken.
- **N_DIGITS=1:** `idx` stays at 0; a frame end occurs every slot.
- **Width of `cnt`:** $clog2(REFRESH_DIV). Width of `idx`: max(1, $clog2(N_DIGITS)).

## Structure
- **Package `display_pkg`:** segment pattern constants (SEG_0..SEG_F, SEG_OFF = 7'h7F), the `seg7_t` 7-bit typedef, and the active-low polarity constants.
- **Sub-module `seg7_decode`:** combinational nibble-to-segment decoder with parameter HEX_EN. It is instantiated once, on the muxed nibble.
- **Top module** holds the counter, index, shadow registers, LZB logic and output registers.

## Test plan
All scenarios use N_DIGITS=4, REFRESH_DIV=4.

1. **Reset:** hold `rst` for 3 cycles with `value`=16'h1234 → `an`=4'hF, `seg`=7'h7F, `dp`=1 throughout and on the cycle after release; the first frame lights 0000 on digits 0–3.
2. **Scan order and decode:** `value`=16'h1234, run 3 frames → in frame 3 each digit is lit for 3 cycles then dark for 1; `an` sequence is E, D, B, 7; `seg` sequence is 0011001, 0110000, 0100100, 1111001; `frame_tick` fires every 16 cycles.
3. **Hex and HEX_EN:** `value`=16'hFACE → `seg` shows E, C, A, F patterns. Rerun with HEX_EN=0 → all four digits show 7'h7F while `an` still cycles.
4. **LZB:** `value`=16'h0050, `lzb_en`=1 → digits 3 and 2 show 7'h7F, digit 1 = 5, digit 0 = 0. With `value`=16'h0000, only digit 0 shows 1000000.
5. **Tearing:** change `value` from 16'h1111 to 16'h2222 while digit 1 is being shown → the rest of that frame still shows 1, the next frame shows 2, and `frame_tick` coincides with the first frame shown as 2.
6. **Decimal point and mid-frame reset:** `dp_in`=4'b0100 → `dp`=0 only while `an`=4'hB. Assert `rst` while digit 2 is lit → outputs go off next edge and the scan resumes at digit 0.
